// File: rtl/laser_cover_eval_if.sv
// Target-stream, centre-capture and score-report signals shared by the
// placement-engine side (master) and the scoring stage (slave).
interface laser_cover_eval_if;
    logic       IN_VALID;
    logic [3:0] X;
    logic [3:0] Y;
    logic       DONE_IN;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic [5:0] COUNT;
    logic [5:0] CNT1;
    logic [5:0] CNT2;
    logic       VALID;
    logic       BUSY;
    logic       OVF;

    modport master (
        output IN_VALID, X, Y, DONE_IN, C1X, C1Y, C2X, C2Y,
        input  COUNT, CNT1, CNT2, VALID, BUSY, OVF
    );

    modport slave (
        input  IN_VALID, X, Y, DONE_IN, C1X, C1Y, C2X, C2Y,
        output COUNT, CNT1, CNT2, VALID, BUSY, OVF
    );
endinterface

// File: rtl/laser_cover_eval.sv
// Scores a two-circle laser placement: buffers one frame of target points,
// then counts the points hit by each circle and by their union.
module laser_cover_eval #(
    parameter int NPTS = 40,
    parameter int R2   = 16
) (
    input logic               CLK,
    input logic               RST,
    laser_cover_eval_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, EVAL, REPORT} state_t;

    localparam logic [5:0] LAST_IDX = 6'(NPTS - 1);
    localparam logic [5:0] END_IDX  = 6'(NPTS);

    state_t     state_q;
    logic [5:0] idx_q;
    logic [5:0] cnt1_q, cnt2_q, cntu_q;
    logic [3:0] c1x_q, c1y_q, c2x_q, c2y_q;
    logic [5:0] count_q, out1_q, out2_q;
    logic       valid_q, busy_q, ovf_q;

    logic [3:0] pt_x_q [NPTS];
    logic [3:0] pt_y_q [NPTS];

    logic       wr_en_d;
    logic [5:0] wr_idx_d;
    logic [3:0] rd_x_d, rd_y_d;
    logic       h1_d, h2_d;

    // Absolute differences come from a 5-bit signed subtract, so 0 vs 15 is
    // a distance of 15, never a wrapped distance of 1.
    function automatic logic hit(input logic [3:0] px, input logic [3:0] py,
                                 input logic [3:0] cx, input logic [3:0] cy);
        logic signed [4:0] ddx, ddy;
        logic [8:0]        ax, ay;
        ddx = $signed({1'b0, px}) - $signed({1'b0, cx});
        ddy = $signed({1'b0, py}) - $signed({1'b0, cy});
        ax  = {5'd0, (ddx[4] ? 4'(-ddx) : ddx[3:0])};
        ay  = {5'd0, (ddy[4] ? 4'(-ddy) : ddy[3:0])};
        return (ax * ax + ay * ay) <= 9'(R2);
    endfunction

    assign wr_en_d  = bus.IN_VALID && (state_q == IDLE || state_q == LOAD);
    assign wr_idx_d = (state_q == IDLE) ? 6'd0 : idx_q;
    assign rd_x_d   = pt_x_q[idx_q];
    assign rd_y_d   = pt_y_q[idx_q];
    assign h1_d     = hit(rd_x_d, rd_y_d, c1x_q, c1y_q);
    assign h2_d     = hit(rd_x_d, rd_y_d, c2x_q, c2y_q);

    // NOTE: the point buffer is deliberately left out of reset; every entry is
    // written during LOAD before EVAL reads it, so a reset would only cost area.
    always_ff @(posedge CLK) begin
        if (wr_en_d) begin
            pt_x_q[wr_idx_d] <= bus.X;
            pt_y_q[wr_idx_d] <= bus.Y;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            cntu_q  <= '0;
            c1x_q   <= '0;
            c1y_q   <= '0;
            c2x_q   <= '0;
            c2y_q   <= '0;
            count_q <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.IN_VALID) begin
                        idx_q   <= 6'd1;
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.DONE_IN) ovf_q <= 1'b1;
                    if (bus.IN_VALID) begin
                        idx_q <= idx_q + 6'd1;
                        if (idx_q == LAST_IDX) state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.IN_VALID) ovf_q <= 1'b1;
                    if (bus.DONE_IN) begin
                        c1x_q   <= bus.C1X;
                        c1y_q   <= bus.C1Y;
                        c2x_q   <= bus.C2X;
                        c2y_q   <= bus.C2Y;
                        idx_q   <= '0;
                        cnt1_q  <= '0;
                        cnt2_q  <= '0;
                        cntu_q  <= '0;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    if (bus.IN_VALID || bus.DONE_IN) ovf_q <= 1'b1;
                    // The edge after the last point is scored publishes the
                    // totals; VALID is high while the state reads REPORT.
                    if (idx_q == END_IDX) begin
                        count_q <= cntu_q;
                        out1_q  <= cnt1_q;
                        out2_q  <= cnt2_q;
                        valid_q <= 1'b1;
                        state_q <= REPORT;
                    end else begin
                        cnt1_q <= cnt1_q + {5'd0, h1_d};
                        cnt2_q <= cnt2_q + {5'd0, h2_d};
                        cntu_q <= cntu_q + {5'd0, (h1_d | h2_d)};
                        idx_q  <= idx_q + 6'd1;
                    end
                end
                REPORT: begin
                    if (bus.IN_VALID) ovf_q <= 1'b1;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.COUNT = count_q;
    assign bus.CNT1  = out1_q;
    assign bus.CNT2  = out2_q;
    assign bus.VALID = valid_q;
    assign bus.BUSY  = busy_q;
    assign bus.OVF   = ovf_q;

endmodule

// File: tb/tb_laser_cover_eval.sv
// Randomised and directed frames scored against a distance-formula reference
// model of the two-circle coverage counts.
module tb_laser_cover_eval;

    localparam int NPTS = 40;
    localparam int R2   = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    laser_cover_eval_if bus ();

    laser_cover_eval #(.NPTS(NPTS), .R2(R2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int px [NPTS];
    int py [NPTS];
    bit exp_ovf = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit covers(input int x, input int y, input int cx, input int cy);
        int dx, dy;
        dx = (x > cx) ? x - cx : cx - x;
        dy = (y > cy) ? y - cy : cy - y;
        return (dx * dx + dy * dy) <= R2;
    endfunction

    function automatic void score(input int c1x, input int c1y, input int c2x, input int c2y,
                                  output int e1, output int e2, output int eu);
        e1 = 0; e2 = 0; eu = 0;
        for (int i = 0; i < NPTS; i++) begin
            bit a, b;
            a = covers(px[i], py[i], c1x, c1y);
            b = covers(px[i], py[i], c2x, c2y);
            e1 += int'(a);
            e2 += int'(b);
            eu += int'(a || b);
        end
    endfunction

    task automatic load_points(input bit gapped, input bit err_load);
        for (int i = 0; i < NPTS; i++) begin
            if (gapped) begin
                bus.IN_VALID = 1'b0;
                tick();
            end
            if (err_load && i == 10) begin
                bus.IN_VALID = 1'b0;
                bus.DONE_IN  = 1'b1;
                exp_ovf      = 1'b1;
                tick();
                bus.DONE_IN  = 1'b0;
            end
            bus.IN_VALID = 1'b1;
            bus.X        = 4'(px[i]);
            bus.Y        = 4'(py[i]);
            tick();
        end
        bus.IN_VALID = 1'b0;
    endtask

    task automatic pulse_done(input int c1x, input int c1y, input int c2x, input int c2y);
        bus.C1X     = 4'(c1x);
        bus.C1Y     = 4'(c1y);
        bus.C2X     = 4'(c2x);
        bus.C2Y     = 4'(c2y);
        bus.DONE_IN = 1'b1;
        tick();
        bus.DONE_IN = 1'b0;
        // Scramble the centre inputs so only the captured copies can be used.
        bus.C1X = 4'($urandom);
        bus.C1Y = 4'($urandom);
        bus.C2X = 4'($urandom);
        bus.C2Y = 4'($urandom);
    endtask

    task automatic run_frame(input string tag, input int c1x, input int c1y,
                             input int c2x, input int c2y, input bit gapped,
                             input bit err_load, input bit err_wait, input bit err_eval);
        int e1, e2, eu, lat;
        bit seen;
        load_points(gapped, err_load);
        if (err_wait) begin
            bus.IN_VALID = 1'b1;
            bus.X        = 4'($urandom);
            bus.Y        = 4'($urandom);
            exp_ovf      = 1'b1;
        end
        tick();
        bus.IN_VALID = 1'b0;
        pulse_done(c1x, c1y, c2x, c2y);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            if (err_eval && k == 5) begin
                bus.IN_VALID = 1'b1;
                bus.X        = 4'(c1x);
                bus.Y        = 4'(c1y);
                exp_ovf      = 1'b1;
            end
            tick();
            bus.IN_VALID = 1'b0;
            if (k == 20) check({tag, ".busy_eval"}, int'(bus.BUSY), 1);
            if (bus.VALID) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        score(c1x, c1y, c2x, c2y, e1, e2, eu);
        check({tag, ".valid_seen"}, int'(seen), 1);
        check({tag, ".latency"}, lat, 41);
        check({tag, ".cnt1"}, int'(bus.CNT1), e1);
        check({tag, ".cnt2"}, int'(bus.CNT2), e2);
        check({tag, ".count"}, int'(bus.COUNT), eu);
        check({tag, ".ovf"}, int'(bus.OVF), int'(exp_ovf));
        tick();
        check({tag, ".valid_pulse"}, int'(bus.VALID), 0);
        check({tag, ".busy_idle"}, int'(bus.BUSY), 0);
        check({tag, ".count_hold"}, int'(bus.COUNT), eu);
        tick();
    endtask

    task automatic fill(input int x, input int y);
        for (int i = 0; i < NPTS; i++) begin
            px[i] = x;
            py[i] = y;
        end
    endtask

    function automatic int near(input int c);
        int v;
        v = c + int'($urandom_range(8)) - 4;
        if (v < 0) v = 0;
        if (v > 15) v = 15;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c [4];
        int any_valid;

        bus.IN_VALID = 1'b0;
        bus.X        = '0;
        bus.Y        = '0;
        bus.DONE_IN  = 1'b0;
        bus.C1X      = '0;
        bus.C1Y      = '0;
        bus.C2X      = '0;
        bus.C2Y      = '0;
        RST          = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        check("rst.count", int'(bus.COUNT), 0);
        check("rst.cnt1", int'(bus.CNT1), 0);
        check("rst.cnt2", int'(bus.CNT2), 0);
        check("rst.valid", int'(bus.VALID), 0);
        check("rst.busy", int'(bus.BUSY), 0);
        check("rst.ovf", int'(bus.OVF), 0);

        // DONE_IN while idle must be ignored.
        pulse_done(8, 8, 8, 8);
        tick();
        check("idle_done.busy", int'(bus.BUSY), 0);

        fill(8, 8);
        run_frame("centre", 8, 8, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        fill(0, 15);
        px[0] = 12; py[0] = 8;
        px[1] = 10; py[1] = 11;
        px[2] = 11; py[2] = 11;
        run_frame("radius", 8, 8, 15, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NPTS; i++) begin
            px[i] = (i < 20) ? 5 : 15;
            py[i] = (i < 20) ? 5 : 15;
        end
        run_frame("overlap", 5, 5, 6, 6, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("disjoint", 5, 5, 14, 14, 1'b0, 1'b0, 1'b0, 1'b0);

        fill(0, 0);
        run_frame("nowrap", 15, 15, 15, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("nowrap_gap", 15, 15, 15, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NPTS; i++) begin
            px[i] = near(6);
            py[i] = near(9);
        end
        run_frame("proto_err", 6, 9, 9, 6, 1'b0, 1'b1, 1'b1, 1'b1);
        run_frame("ovf_sticky", 6, 9, 2, 2, 1'b1, 1'b0, 1'b0, 1'b0);

        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_clear", int'(bus.OVF), 0);

        // Abort in the middle of evaluation.
        fill(3, 3);
        load_points(1'b0, 1'b0);
        tick();
        pulse_done(3, 3, 4, 4);
        repeat (20) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort.valid", int'(bus.VALID), 0);
        check("abort.count", int'(bus.COUNT), 0);
        check("abort.cnt1", int'(bus.CNT1), 0);
        check("abort.cnt2", int'(bus.CNT2), 0);
        check("abort.busy", int'(bus.BUSY), 0);
        any_valid = 0;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (bus.VALID) any_valid = 1;
        end
        check("abort.no_valid", any_valid, 0);
        run_frame("after_abort", 3, 3, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            for (int j = 0; j < 4; j++) c[j] = int'($urandom_range(15));
            for (int i = 0; i < NPTS; i++) begin
                case ($urandom_range(2))
                    0: begin px[i] = near(c[0]); py[i] = near(c[1]); end
                    1: begin px[i] = near(c[2]); py[i] = near(c[3]); end
                    default: begin
                        px[i] = int'($urandom_range(15));
                        py[i] = int'($urandom_range(15));
                    end
                endcase
            end
            run_frame($sformatf("rand%0d", f), c[0], c[1], c[2], c[3],
                      1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
